effect_param_sequencer: RTL

//  Front-panel parameter controller for the audio effects chain. It debounces four

---
 rtl/effect_param_sequencer_if.sv | 26 ++
 rtl/effect_param_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/effect_param_sequencer_if.sv
// Front-panel key / effect-parameter bundle.
// master: drives raw keys and the sample tick (board side).
// slave: the sequencer, which returns the committed effect parameters.
interface effect_param_sequencer_if;
  logic               key_mode;
  logic               key_up;
  logic               key_down;
  logic               key_default;
  logic               sample_tick;
  logic signed [15:0] gainNum;
  logic signed [15:0] gainDen;
  logic        [11:0] echoDelay;
  logic        [3:0]  volume;
  logic        [1:0]  effect_sel;
  logic               param_update;

  modport master (
    output key_mode, key_up, key_down, key_default, sample_tick,
    input  gainNum, gainDen, echoDelay, volume, effect_sel, param_update
  );

  modport slave (
    input  key_mode, key_up, key_down, key_default, sample_tick,
    output gainNum, gainDen, echoDelay, volume, effect_sel, param_update
  );
endinterface

// File: rtl/effect_param_sequencer.sv
// Effect parameter sequencer: debounces four active-low keys, edits shadow
// copies of the distortion/echo/volume parameters and commits them to the
// datapath only on a sample_tick, so no stage sees a mid-sample change.
// Optional feature macro: AUTO_REPEAT_EN (held up/down keys auto-repeat).

// Per-key 2-flop synchroniser plus stable-level debounce counter.
module effect_param_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic key_n,
  output logic stable
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Accept a new level only after it has differed from the stable level for DEBOUNCE_CYCLES cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], key_n};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module effect_param_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GAIN_MIN        = 1,
  parameter int GAIN_MAX        = 50,
  parameter int DELAY_STEP      = 256,
  parameter int DELAY_MAX       = 3840,
  parameter int VOL_MAX         = 15,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input logic                     CLK,
  input logic                     RST_N,
  effect_param_sequencer_if.slave bus
);
  localparam int NUM_KEYS = 4;  // bit order: {default, mode, down, up}
  localparam logic signed [15:0] G_MIN   = 16'(GAIN_MIN);
  localparam logic signed [15:0] G_MAX   = 16'(GAIN_MAX);
  localparam logic signed [15:0] G_RST   = 16'sd1;
  localparam logic [11:0]        D_STEP  = 12'(DELAY_STEP);
  localparam logic [11:0]        D_MAX   = 12'(DELAY_MAX);
  localparam logic [11:0]        D_RST   = 12'd1024;
  localparam logic [3:0]         V_MAX   = 4'(VOL_MAX);
  localparam logic [3:0]         V_RST   = 4'd8;

  typedef enum logic {IDLE, PENDING} state_t;

  logic [NUM_KEYS-1:0] key_raw, lvl, lvl_d, press;
  logic                ev_def, ev_mode;
  logic [1:0]          step;  // {down, up}

  assign key_raw = {bus.key_default, bus.key_mode, bus.key_down, bus.key_up};

  genvar g;
  for (g = 0; g < NUM_KEYS; g++) begin : g_key
    effect_param_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .key_n  (key_raw[g]),
      .stable (lvl[g])
    );
  end

  // Previous stable levels, for 1->0 press detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lvl_d <= '1;
    else        lvl_d <= lvl;
  end

  assign press   = lvl_d & ~lvl;
  assign ev_def  = press[3];
  assign ev_mode = press[2];

`ifdef AUTO_REPEAT_EN
  localparam int            RW        = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_RATE - 1);

  logic [1:0][RW-1:0] rpt_cnt;
  logic [1:0]         rpt_first, rpt;

  for (g = 0; g < 2; g++) begin : g_rpt
    assign rpt[g] = !lvl[g] && !(ev_def || ev_mode) &&
                    (rpt_cnt[g] == (rpt_first[g] ? RPT_FIRST : RPT_NEXT));
  end

  // Time how long up/down has been held; restart on release or a higher-priority event
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rpt_cnt   <= '0;
      rpt_first <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (lvl[i] || ev_def || ev_mode) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
        end else if (rpt[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b0;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign step = press[1:0] | rpt;
`else
  assign step = press[1:0];
`endif

  state_t             state;
  logic signed [15:0] sh_gain, sh_gain_n, gain_q;
  logic [11:0]        sh_echo, sh_echo_n, echo_q;
  logic [3:0]         sh_vol, sh_vol_n, vol_q;
  logic [1:0]         sel, sel_n;
  logic               mod, upd;

  // Apply this cycle's highest-priority event to the shadows; mod flags a shadow edit
  always_comb begin
    sh_gain_n = sh_gain;
    sh_echo_n = sh_echo;
    sh_vol_n  = sh_vol;
    sel_n     = sel;
    mod       = 1'b0;
    if (ev_def) begin
      sh_gain_n = G_RST;
      sh_echo_n = D_RST;
      sh_vol_n  = V_RST;
      mod       = 1'b1;
    end else if (ev_mode) begin
      sel_n = sel + 2'd1;
    end else if (step == 2'b01 || step == 2'b10) begin
      case (sel)
        2'd0: begin
          mod = 1'b1;
          if (step[0]) sh_gain_n = (sh_gain >= G_MAX) ? G_MAX : sh_gain + 16'sd1;
          else         sh_gain_n = (sh_gain <= G_MIN) ? G_MIN : sh_gain - 16'sd1;
        end
        2'd1: begin
          mod = 1'b1;
          if (step[0]) sh_echo_n = (sh_echo >= D_MAX - D_STEP) ? D_MAX : sh_echo + D_STEP;
          else         sh_echo_n = (sh_echo <= D_STEP + D_STEP) ? D_STEP : sh_echo - D_STEP;
        end
        2'd2: begin
          mod = 1'b1;
          if (step[0]) sh_vol_n = (sh_vol >= V_MAX) ? V_MAX : sh_vol + 4'd1;
          else         sh_vol_n = (sh_vol == 4'd0) ? 4'd0 : sh_vol - 4'd1;
        end
        default: ;  // bypass has no parameter
      endcase
    end
  end

  // Commit FSM: shadows always advance; outputs take the pre-event shadow on a tick in PENDING
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      sh_gain <= G_RST;
      sh_echo <= D_RST;
      sh_vol  <= V_RST;
      gain_q  <= G_RST;
      echo_q  <= D_RST;
      vol_q   <= V_RST;
      sel     <= 2'd0;
      upd     <= 1'b0;
    end else begin
      sh_gain <= sh_gain_n;
      sh_echo <= sh_echo_n;
      sh_vol  <= sh_vol_n;
      sel     <= sel_n;
      if (state == PENDING && bus.sample_tick) begin
        gain_q <= sh_gain;
        echo_q <= sh_echo;
        vol_q  <= sh_vol;
        upd    <= 1'b1;
        state  <= mod ? PENDING : IDLE;
      end else begin
        upd <= 1'b0;
        if (mod) state <= PENDING;
      end
    end
  end

  assign bus.gainNum      = gain_q;
  assign bus.gainDen      = 16'sd1;
  assign bus.echoDelay    = echo_q;
  assign bus.volume       = vol_q;
  assign bus.effect_sel   = sel;
  assign bus.param_update = upd;
endmodule
